// File: rtl/bcd_score_renderer.sv
// bcd_score_renderer
//   Converts a binary score to DIGITS decimal digits with a serial double-dabble
//   and then draws them as 5x5 glyphs, one VGA pixel per clock. Every pixel of
//   every glyph cell is written, either FG or BG, so the previous score is erased.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-low
//   draw       start request, only sampled while idle
//   scoreIn    unsigned binary score, captured when draw is accepted
//   xOut/yOut  pixel coordinates, hold their last value outside rendering
//   colourOut  pixel colour, 0 outside rendering
//   plot       VGA write enable, one per rendered pixel
//   busy       high from the cycle after an accepted draw through the last pixel
//   done       one-cycle completion pulse
module bcd_score_renderer #(
  parameter int         DIGITS   = 4,
  parameter int         SCORE_W  = 15,
  parameter int         X0       = 10,
  parameter int         Y0       = 3,
  parameter int         PITCH    = 6,
  parameter logic [2:0] FG       = 3'b111,
  parameter logic [2:0] BG       = 3'b000,
  parameter bit         BLANK_LZ = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               draw,
  input  logic [SCORE_W-1:0] scoreIn,
  output logic [7:0]         xOut,
  output logic [7:0]         yOut,
  output logic [2:0]         colourOut,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, RENDER, DONE} state_t;

  state_t             state, state_next;
  logic [SCORE_W-1:0] shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               sat_q;
  logic [4:0]         bit_cnt;
  logic [2:0]         dig_q, row_q, col_q;

  logic [7:0]         x_p0, y_p0;
  logic [2:0]         colour_p0;
  logic               vld_p0, busy_p0, done_p0;

  logic [BCD_W-1:0]   adj, bcd_step, src_bcd;
  logic               sat_step, src_sat, conv_last, render_fin, emit, lit;
  logic [2:0]         src_d, src_r, src_c, nxt_d, nxt_r, nxt_c;
  logic [3:0]         src_val;
  logic [4:0]         row_bits;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturation: an overflowed conversion renders every digit as 9.
  function automatic logic [3:0] digit_val(input logic [BCD_W-1:0] v, input logic sat,
                                           input logic [2:0] d);
    if (sat) return 4'd9;
    return v[4*(DIGITS-1-int'(d)) +: 4];
  endfunction

  // Leading-zero blanking: digit d is blank when it and all more significant
  // digits are zero. The least significant digit always shows.
  function automatic logic digit_blank(input logic [BCD_W-1:0] v, input logic sat,
                                       input logic [2:0] d);
    logic all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i <= int'(d) && v[4*(DIGITS-1-i) +: 4] != 4'd0) all_zero = 1'b0;
    end
    return BLANK_LZ && !sat && (int'(d) != DIGITS-1) && all_zero;
  endfunction

  // Font rows, bit 4 is the leftmost column; row 0 sits in the top 5 bits.
  function automatic logic [4:0] font_row(input logic [3:0] v, input logic [2:0] r);
    logic [24:0] g;
    case (v)
      4'd0:    g = 25'b01110_10001_10001_10001_01110;
      4'd1:    g = 25'b00100_01100_00100_00100_01110;
      4'd2:    g = 25'b11111_00001_11111_10000_11111;
      4'd3:    g = 25'b11111_00001_11111_00001_11111;
      4'd4:    g = 25'b10010_10010_11111_00010_00010;
      4'd5:    g = 25'b11111_10000_11111_00001_11111;
      4'd6:    g = 25'b11111_10000_11111_10001_11111;
      4'd7:    g = 25'b11111_00001_00010_00100_01000;
      4'd8:    g = 25'b11111_10001_11111_10001_11111;
      4'd9:    g = 25'b11111_10001_11111_00001_11111;
      default: g = 25'd0;
    endcase
    return g[24-5*int'(r) -: 5];
  endfunction

  function automatic logic [7:0] pixel_x(input logic [2:0] d, input logic [2:0] c);
    int t;
    t = X0 + int'(d) * PITCH + int'(c);
    return t[7:0];
  endfunction

  function automatic logic [7:0] pixel_y(input logic [2:0] r);
    int t;
    t = Y0 + int'(r);
    return t[7:0];
  endfunction

  always_comb begin
    adj        = dd_adjust(bcd_q);
    bcd_step   = {adj[BCD_W-2:0], shift_q[SCORE_W-1]};
    // A set top bit after correction means a digit >= 10 would be carried out.
    sat_step   = sat_q | adj[BCD_W-1];
    conv_last  = (bit_cnt == 5'(SCORE_W-1));
    render_fin = (dig_q == 3'(DIGITS));

    // The first pixel leaves on the final conversion edge, so it is drawn
    // from the conversion result still on its way into bcd_q.
    src_bcd = bcd_q;
    src_sat = sat_q;
    src_d   = dig_q;
    src_r   = row_q;
    src_c   = col_q;
    if (state == CONVERT) begin
      src_bcd = bcd_step;
      src_sat = sat_step;
      src_d   = 3'd0;
      src_r   = 3'd0;
      src_c   = 3'd0;
    end

    src_val  = digit_val(src_bcd, src_sat, src_d);
    row_bits = font_row(src_val, src_r);
    lit      = row_bits[3'd4 - src_c] && !digit_blank(src_bcd, src_sat, src_d);

    nxt_d = src_d;
    nxt_r = src_r;
    nxt_c = src_c + 3'd1;
    if (src_c == 3'd4) begin
      nxt_c = 3'd0;
      nxt_r = src_r + 3'd1;
      if (src_r == 3'd4) begin
        nxt_r = 3'd0;
        nxt_d = src_d + 3'd1;
      end
    end

    emit = ((state == CONVERT) && conv_last) || ((state == RENDER) && !render_fin);

    state_next = state;
    case (state)
      IDLE:    if (draw) state_next = CONVERT;
      CONVERT: if (conv_last) state_next = RENDER;
      RENDER:  if (render_fin) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Stage p0: conversion state and registered pixel outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_q   <= '0;
      bcd_q     <= '0;
      sat_q     <= 1'b0;
      bit_cnt   <= '0;
      dig_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      x_p0      <= '0;
      y_p0      <= '0;
      colour_p0 <= '0;
      vld_p0    <= 1'b0;
      busy_p0   <= 1'b0;
      done_p0   <= 1'b0;
    end else begin
      done_p0 <= (state == RENDER) && render_fin;
      case (state)
        IDLE: begin
          if (draw) begin
            shift_q <= scoreIn;
            bcd_q   <= '0;
            sat_q   <= 1'b0;
            bit_cnt <= '0;
            busy_p0 <= 1'b1;
          end
        end
        CONVERT: begin
          shift_q <= shift_q << 1;
          bcd_q   <= bcd_step;
          sat_q   <= sat_step;
          bit_cnt <= bit_cnt + 5'd1;
        end
        RENDER: if (render_fin) busy_p0 <= 1'b0;
        default: ;
      endcase

      if (emit) begin
        x_p0      <= pixel_x(src_d, src_c);
        y_p0      <= pixel_y(src_r);
        colour_p0 <= lit ? FG : BG;
        vld_p0    <= 1'b1;
        dig_q     <= nxt_d;
        row_q     <= nxt_r;
        col_q     <= nxt_c;
      end else begin
        colour_p0 <= '0;
        vld_p0    <= 1'b0;
      end
    end
  end

  assign xOut      = x_p0;
  assign yOut      = y_p0;
  assign colourOut = colour_p0;
  assign plot      = vld_p0;
  assign busy      = busy_p0;
  assign done      = done_p0;

endmodule

// File: tb/tb_bcd_score_renderer.sv
// Bench for bcd_score_renderer: two instances (leading-zero blanking on and off)
// share all inputs; every cycle of every draw is compared against expectations
// built from a per-vector table of hand-computed decimal digits.
module tb_bcd_score_renderer;
  localparam int SW = 15;

  logic          clock = 1'b0;
  logic          reset, draw;
  logic [SW-1:0] scoreIn;
  logic [7:0]    x_a, y_a, x_b, y_b;
  logic [2:0]    col_a, col_b;
  logic          plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  always #5 clock = ~clock;

  bcd_score_renderer #(.BLANK_LZ(1)) dut_a (
    .clock(clock), .reset(reset), .draw(draw), .scoreIn(scoreIn),
    .xOut(x_a), .yOut(y_a), .colourOut(col_a), .plot(plot_a),
    .busy(busy_a), .done(done_a));

  bcd_score_renderer #(.BLANK_LZ(0)) dut_b (
    .clock(clock), .reset(reset), .draw(draw), .scoreIn(scoreIn),
    .xOut(x_b), .yOut(y_b), .colourOut(col_b), .plot(plot_b),
    .busy(busy_b), .done(done_b));

  typedef struct {
    logic [SW-1:0] score;
    logic [15:0]   digs;   // expected rendered digits, MSD in the top nibble
    logic [3:0]    lz;     // bit 3 = MSD blanked when BLANK_LZ=1
    int            inj1;   // cycle after accept in which draw is pulsed (0 = none)
    int            inj2;
    int            abort;  // cycle after accept in which reset is pulled low (0 = none)
  } vec_t;

  vec_t        vecs [11];
  logic [24:0] font [10];
  int          checks = 0;
  int          passes = 0;
  logic [7:0]  last_x, last_y;

  task automatic check(input string name, input int n, input logic [21:0] act,
                       input logic [21:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got {busy,done,plot,col,x,y}=%h expected %h",
                  name, n, act, exp);
  endtask

  task automatic run(input int idx, input vec_t v);
    logic [21:0] exp_a, exp_b;
    logic        e_busy, e_done, e_plot, fbit;
    logic [2:0]  ca, cb;
    logic [3:0]  dg;
    logic [24:0] g;
    int          last_n, p, d, r, c;
    string       na, nb;
    na = $sformatf("v%0d_lz1", idx);
    nb = $sformatf("v%0d_lz0", idx);
    last_n = (v.abort > 0) ? v.abort + 20 : SW + 102;
    draw    = 1'b1;
    scoreIn = v.score;
    @(negedge clock);
    draw = 1'b0;
    for (int n = 1; n <= last_n; n++) begin
      if (n > 1) @(negedge clock);
      ca = 3'd0;
      cb = 3'd0;
      if (v.abort > 0 && n > v.abort) begin
        e_busy = 1'b0; e_done = 1'b0; e_plot = 1'b0;
        last_x = 8'd0; last_y = 8'd0;
      end else begin
        e_busy = (n <= SW + 100);
        e_done = (n == SW + 101);
        e_plot = (n >= SW + 1) && (n <= SW + 100);
        if (e_plot) begin
          p = n - SW - 1;
          d = p / 25;
          r = (p % 25) / 5;
          c = p % 5;
          last_x = 8'(10 + 6 * d + c);
          last_y = 8'(3 + r);
          dg   = v.digs[4*(3-d) +: 4];
          g    = font[dg];
          fbit = g[24 - 5*r - c];
          ca   = (fbit && !v.lz[3-d]) ? 3'b111 : 3'b000;
          cb   = fbit ? 3'b111 : 3'b000;
        end
      end
      exp_a = {e_busy, e_done, e_plot, ca, last_x, last_y};
      exp_b = {e_busy, e_done, e_plot, cb, last_x, last_y};
      check(na, n, {busy_a, done_a, plot_a, col_a, x_a, y_a}, exp_a);
      check(nb, n, {busy_b, done_b, plot_b, col_b, x_b, y_b}, exp_b);
      if (n == 3) scoreIn = ~v.score;
      draw  = (n == v.inj1) || (n == v.inj2);
      reset = !(n == v.abort);
    end
    draw  = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    font[0] = 25'b01110_10001_10001_10001_01110;
    font[1] = 25'b00100_01100_00100_00100_01110;
    font[2] = 25'b11111_00001_11111_10000_11111;
    font[3] = 25'b11111_00001_11111_00001_11111;
    font[4] = 25'b10010_10010_11111_00010_00010;
    font[5] = 25'b11111_10000_11111_00001_11111;
    font[6] = 25'b11111_10000_11111_10001_11111;
    font[7] = 25'b11111_00001_00010_00100_01000;
    font[8] = 25'b11111_10001_11111_10001_11111;
    font[9] = 25'b11111_10001_11111_00001_11111;

    vecs[0]  = '{15'd0,     16'h0000, 4'b1110, 0,  0,        0};
    vecs[1]  = '{15'd1234,  16'h1234, 4'b0000, 0,  0,        0};
    vecs[2]  = '{15'd12000, 16'h9999, 4'b0000, 0,  0,        0};
    vecs[3]  = '{15'd7,     16'h0007, 4'b1110, 0,  0,        0};
    vecs[4]  = '{15'd105,   16'h0105, 4'b1000, 0,  0,        0};
    vecs[5]  = '{15'd9999,  16'h9999, 4'b0000, 0,  0,        0};
    vecs[6]  = '{15'd10000, 16'h9999, 4'b0000, 0,  0,        0};
    vecs[7]  = '{15'd32767, 16'h9999, 4'b0000, 0,  0,        0};
    vecs[8]  = '{15'd1234,  16'h1234, 4'b0000, 50, SW + 101, 0};
    vecs[9]  = '{15'd4567,  16'h4567, 4'b0000, 0,  0,        60};
    vecs[10] = '{15'd890,   16'h0890, 4'b1000, 0,  0,        0};

    reset   = 1'b0;
    draw    = 1'b0;
    scoreIn = '0;
    last_x  = 8'd0;
    last_y  = 8'd0;
    repeat (3) @(negedge clock);
    check("reset_lz1", 0, {busy_a, done_a, plot_a, col_a, x_a, y_a}, 22'd0);
    check("reset_lz0", 0, {busy_b, done_b, plot_b, col_b, x_b, y_b}, 22'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 11; i++) run(i, vecs[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bcd_score_renderer.md
BCD_SCORE_RENDERER -- requirements
Module: bcd_score_renderer

Interface
REQ-001 Parameter DIGITS, default 4: number of decimal digits rendered, range 1..6.
REQ-002 Parameter SCORE_W, default 15: score input width, range 4..20.
REQ-003 Parameter X0, default 10; Y0, default 3: screen origin of the most significant digit, top-left pixel.
REQ-004 Parameter PITCH, default 6: x distance between digit origins, range 5..16.
REQ-005 Parameter FG, default 3'b111; BG, default 3'b000: lit-pixel colour and unlit-pixel colour.
REQ-006 Parameter BLANK_LZ, default 1: 1 draws leading zeros in BG colour.
REQ-007 clock  in  1  system clock, all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 draw  in  1  start request, sampled only in IDLE.
REQ-010 scoreIn  in  SCORE_W  unsigned binary score.
REQ-011 xOut  out  8  VGA x coordinate.
REQ-012 yOut  out  8  VGA y coordinate.
REQ-013 colourOut  out  3  VGA pixel colour.
REQ-014 plot  out  1  VGA write enable.
REQ-015 busy  out  1  high from the cycle after an accepted draw through the last pixel.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, CONVERT, RENDER, DONE; IDLE->CONVERT on draw; CONVERT->RENDER after SCORE_W cycles; RENDER->DONE after the last pixel; DONE->IDLE unconditionally.
REQ-018 On the edge where draw=1 in IDLE, scoreIn is latched; later scoreIn changes have no effect until the next accepted draw.
REQ-019 CONVERT performs shift-and-add-3 (double dabble), one bit per cycle, MSB first, into DIGITS BCD nibbles; no combinational divide and no subtract loop.
REQ-020 Saturation: if the latched score >= 10^DIGITS, every digit renders as 9.
REQ-021 RENDER emits exactly one pixel per cycle, 25 per digit, order: digit MSD..LSD, row 0..4, column 0..4.
REQ-022 Pixel position: xOut = X0 + d*PITCH + c, yOut = Y0 + r (d = digit index from MSD, r = row, c = column), computed modulo 256.
REQ-023 plot=1 for every RENDER pixel, lit or not; colourOut=FG if the font bit is set, else BG, so any previous glyph is erased.
REQ-024 Font rows, bit4 = column 0: 0 {01110,10001,10001,10001,01110}; 1 {00100,01100,00100,00100,01110}; 2 {11111,00001,11111,10000,11111}; 3 {11111,00001,11111,00001,11111}; 4 {10010,10010,11111,00010,00010}; 5 {11111,10000,11111,00001,11111}; 6 {11111,10000,11111,10001,11111}; 7 {11111,00001,00010,00100,01000}; 8 {11111,10001,11111,10001,11111}; 9 {11111,10001,11111,00001,11111}.
REQ-025 BLANK_LZ=1: every zero digit that precedes the first non-zero digit is drawn entirely in BG; the LSD is never blanked.
REQ-026 Timing: draw accepted at edge k -> busy=1 from cycle k+1; CONVERT occupies cycles k+1..k+SCORE_W; pixels occur in cycles k+SCORE_W+1..k+SCORE_W+25*DIGITS; done=1 only in cycle k+SCORE_W+25*DIGITS+1, with busy=0 and plot=0 in that cycle.
REQ-027 draw while not IDLE (including the DONE cycle) is ignored; draw in the first IDLE cycle after DONE is accepted.
REQ-028 All outputs are registered; outside RENDER, plot=0 and colourOut=0, and xOut/yOut hold their last values.

Reset
REQ-029 reset=0 at any edge forces IDLE and sets xOut=0, yOut=0, colourOut=0, plot=0, busy=0, done=0, and clears the BCD and shift registers, including mid-CONVERT or mid-RENDER; no done pulse is produced for an aborted render.
REQ-030 The first draw after reset release is accepted normally.

Verification
REQ-031 Defaults, scoreIn=0: 100 pixels, all plot=1; digits 0-2 all BG; digit 3 forms glyph '0', first FG pixel at (29,3); done at k+116.
REQ-032 scoreIn=1234: captured lit pattern matches glyphs 1,2,3,4 at x origins 10,16,22,28; first pixel (10,3) is BG, pixel (12,3) is FG.
REQ-033 scoreIn=12000: renders 9999 (saturation).
REQ-034 BLANK_LZ=1, scoreIn=7: only digit 3 has FG pixels; with BLANK_LZ=0, digits 0-2 show '0'.
REQ-035 draw pulsed at k+50 during RENDER, and again in the DONE cycle: both ignored; single done pulse at k+116.
REQ-036 reset=0 at k+60: next cycle plot=0, busy=0, xOut=0, no done pulse; a new draw then completes with correct timing.
